// File: rtl/y86_seq_sequencer.sv
// rtl/y86_seq_sequencer.sv - multi-cycle stage sequencer for the Y86 SEQ core
// Owns the PC, walks each instruction through six stages and latches the architectural status.
module y86_seq_sequencer #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 64,
    parameter int RESET_PC  = 0,
    parameter int CNT_W     = 32,
    parameter int MAX_INSTR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              stall,
    input  logic              imem_error,
    input  logic              instr_invalid,
    input  logic [3:0]        icode,
    input  logic              dmem_error,
    input  logic [DATA_W-1:0] new_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_en,
    output logic              decode_en,
    output logic              exec_en,
    output logic              mem_en,
    output logic              wb_en,
    output logic              pc_en,
    output logic [2:0]        stat,
    output logic              halted,
    output logic [CNT_W-1:0]  instr_count,
    output logic [CNT_W-1:0]  cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
    } state_t;

    localparam logic [2:0]       STAT_AOK = 3'd1;
    localparam logic [2:0]       STAT_HLT = 3'd2;
    localparam logic [2:0]       STAT_ADR = 3'd3;
    localparam logic [2:0]       STAT_INS = 3'd4;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(MAX_INSTR);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [2:0]        stat_q, stat_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d;
    logic [CNT_W-1:0]  ccnt_q, ccnt_d;
    logic [5:0]        en_q, en_d;
    logic [CNT_W-1:0]  icnt_inc;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        stat_d   = stat_q;
        icnt_d   = icnt_q;
        ccnt_d   = ccnt_q;
        icnt_inc = (icnt_q == CNT_MAX) ? icnt_q : icnt_q + 1'b1;

        // Stalled cycles still count as busy time.
        if (state_q != S_IDLE && state_q != S_HALT && ccnt_q != CNT_MAX)
            ccnt_d = ccnt_q + 1'b1;

        if (!stall) begin
            case (state_q)
                S_IDLE:   if (run) state_d = S_FETCH;
                S_FETCH: begin
                    if (imem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else if (instr_invalid) begin
                        stat_d  = STAT_INS;
                        state_d = S_HALT;
                    end else if (icode == 4'd0) begin
                        stat_d  = STAT_HLT;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: state_d = S_EXEC;
                S_EXEC:   state_d = S_MEM;
                S_MEM: begin
                    if (dmem_error) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        state_d = S_WB;
                    end
                end
                S_WB:     state_d = S_PCUPD;
                S_PCUPD: begin
                    if (new_pc[DATA_W-1:ADDR_W] != '0) begin
                        stat_d  = STAT_ADR;
                        state_d = S_HALT;
                    end else begin
                        pc_d   = new_pc[ADDR_W-1:0];
                        icnt_d = icnt_inc;
                        if (MAX_INSTR != 0 && icnt_inc == LIMIT) begin
                            stat_d  = STAT_HLT;
                            state_d = S_HALT;
                        end else begin
                            state_d = run ? S_FETCH : S_IDLE;
                        end
                    end
                end
                default:  state_d = S_HALT;
            endcase
        end

        // Enables are registered alongside the state so they are glitch-free outputs.
        case (state_d)
            S_FETCH:  en_d = 6'b000001;
            S_DECODE: en_d = 6'b000010;
            S_EXEC:   en_d = 6'b000100;
            S_MEM:    en_d = 6'b001000;
            S_WB:     en_d = 6'b010000;
            S_PCUPD:  en_d = 6'b100000;
            default:  en_d = 6'b000000;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            stat_q  <= STAT_AOK;
            icnt_q  <= '0;
            ccnt_q  <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stat_q  <= stat_d;
            icnt_q  <= icnt_d;
            ccnt_q  <= ccnt_d;
            en_q    <= en_d;
        end
    end

    assign pc          = pc_q;
    assign stat        = stat_q;
    assign halted      = (state_q == S_HALT);
    assign instr_count = icnt_q;
    assign cycle_count = ccnt_q;
    assign fetch_en    = en_q[0];
    assign decode_en   = en_q[1];
    assign exec_en     = en_q[2];
    assign mem_en      = en_q[3];
    assign wb_en       = en_q[4];
    assign pc_en       = en_q[5];

endmodule
